// File: rtl/xh_touch_key.sv
// xh_touch_key: turns touch-panel coordinate reports into debounced button events for the
// seven on-screen buttons (1280x720 screen space), with auto-repeat on the +/- buttons.
//
// Ports:
//   pix_clk      system clock
//   rstn         asynchronous active-low reset
//   touch_valid  one-cycle strobe, a new touch report is present
//   touch_down   finger present in this report
//   touch_x/y    report coordinates
//   key_pulse    one-cycle press / auto-repeat event
//   key_code     button ID of the last event, held until reset
//   key_rep      high with key_pulse when the event is an auto-repeat
//   key_release  one-cycle pulse when the held button is released
//   hold_id      button currently held, 0 if none
//
// All event outputs are registered: they appear the cycle after the FSM decides on them.
module xh_touch_key #(
    parameter int unsigned X_BITS         = 13,
    parameter int unsigned Y_BITS         = 13,
    parameter int unsigned DEB_CYCLES     = 1485000,
    parameter int unsigned REPEAT_DELAY   = 37125000,
    parameter int unsigned REPEAT_PERIOD  = 7425000,
    parameter int unsigned TIMEOUT_CYCLES = 7425000,
    parameter int unsigned CNT_BITS       = 26
) (
    input  logic              pix_clk,
    input  logic              rstn,
    input  logic              touch_valid,
    input  logic              touch_down,
    input  logic [X_BITS-1:0] touch_x,
    input  logic [Y_BITS-1:0] touch_y,
    output logic              key_pulse,
    output logic [2:0]        key_code,
    output logic              key_rep,
    output logic              key_release,
    output logic [2:0]        hold_id
);

    localparam logic [CNT_BITS-1:0] DebLast   = CNT_BITS'(DEB_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] DelayLast = CNT_BITS'(REPEAT_DELAY - 1);
    localparam logic [CNT_BITS-1:0] PerLast   = CNT_BITS'(REPEAT_PERIOD - 1);
    localparam logic [CNT_BITS-1:0] ToLast    = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CntOne    = CNT_BITS'(1);

    // Comparison widths: at least 32 bits so rectangle bounds never truncate.
    localparam int unsigned XW = (X_BITS > 32) ? X_BITS : 32;
    localparam int unsigned YW = (Y_BITS > 32) ? Y_BITS : 32;

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

    // ------------------------------------------------------------------ input stage
    logic              smp_q;
    logic              down_q;
    logic [X_BITS-1:0] x_q;
    logic [Y_BITS-1:0] y_q;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            smp_q  <= 1'b0;
            down_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            smp_q <= touch_valid;
            if (touch_valid) begin
                down_q <= touch_down;
                x_q    <= touch_x;
                y_q    <= touch_y;
            end
        end
    end

    // ------------------------------------------------------------------ hit-test
    logic [XW-1:0] xw;
    logic [YW-1:0] yw;
    logic [2:0]    hit;

    assign xw = XW'(x_q);
    assign yw = YW'(y_q);

    function automatic logic in_box(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                    input int unsigned x0, input int unsigned x1,
                                    input int unsigned y0, input int unsigned y1);
        return (x >= XW'(x0)) && (x <= XW'(x1)) && (y >= YW'(y0)) && (y <= YW'(y1));
    endfunction

    always_comb begin
        hit = 3'd0;
        if (down_q) begin
            if      (in_box(xw, yw,  16,  240, 244, 356)) hit = 3'd1;
            else if (in_box(xw, yw, 272,  496, 244, 356)) hit = 3'd2;
            else if (in_box(xw, yw, 272,  496, 444, 556)) hit = 3'd3;
            else if (in_box(xw, yw, 780, 1004,  44, 156)) hit = 3'd4;
            else if (in_box(xw, yw, 528,  752, 244, 356)) hit = 3'd5;
            else if (in_box(xw, yw, 528,  752, 444, 556)) hit = 3'd6;
            else if (in_box(xw, yw,  16,  240, 444, 556)) hit = 3'd7;
        end
    end

    // ------------------------------------------------------------------ FSM
    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] timer_q, timer_d;
    logic [CNT_BITS-1:0] gap_q, gap_d;
    logic [2:0]          cand_q, cand_d;
    logic [2:0]          code_q, code_d;
    logic [2:0]          hold_q, hold_d;
    logic                rep_on_q, rep_on_d;   // first repeat already issued
    logic                pulse_q, pulse_d;
    logic                rep_q, rep_d;
    logic                rel_q, rel_d;

    logic match, mismatch, is_rep_key;

    assign match      = smp_q && (hit == cand_q);
    assign mismatch   = smp_q && (hit != cand_q);
    assign is_rep_key = (cand_q == 3'd5) || (cand_q == 3'd6);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        cand_d   = cand_q;
        code_d   = code_q;
        hold_d   = hold_q;
        rep_on_d = rep_on_q;
        pulse_d  = 1'b0;
        rep_d    = 1'b0;
        rel_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (smp_q && (hit != 3'd0)) begin
                    state_d = StDebounce;
                    cand_d  = hit;
                    timer_d = '0;
                end
            end
            StDebounce: begin
                timer_d = timer_q + CntOne;
                if (mismatch) begin
                    state_d = StIdle;
                end else if (timer_q == DebLast) begin
                    // Debounce completion outranks the report-gap timeout.
                    state_d  = StPressed;
                    timer_d  = '0;
                    gap_d    = '0;
                    rep_on_d = 1'b0;
                    pulse_d  = 1'b1;
                    code_d   = cand_q;
                    hold_d   = cand_q;
                end else if (!smp_q && (timer_q == ToLast)) begin
                    state_d = StIdle;
                end
            end
            StPressed: begin
                timer_d = timer_q + CntOne;
                gap_d   = match ? '0 : gap_q + CntOne;
                // A release in the same cycle as a due repeat suppresses the repeat.
                if (mismatch || (!smp_q && (gap_q == ToLast))) begin
                    state_d = StRelease;
                    timer_d = '0;
                end else if (is_rep_key && (timer_q == (rep_on_q ? PerLast : DelayLast))) begin
                    pulse_d  = 1'b1;
                    rep_d    = 1'b1;
                    code_d   = cand_q;
                    timer_d  = '0;
                    rep_on_d = 1'b1;
                end
            end
            StRelease: begin
                timer_d = timer_q + CntOne;
                if (match) begin
                    // Bounce back: silent return, repeat schedule starts over.
                    state_d  = StPressed;
                    timer_d  = '0;
                    gap_d    = '0;
                    rep_on_d = 1'b0;
                end else if (timer_q == DebLast) begin
                    state_d = StIdle;
                    rel_d   = 1'b1;
                    hold_d  = 3'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            gap_q    <= '0;
            cand_q   <= 3'd0;
            code_q   <= 3'd0;
            hold_q   <= 3'd0;
            rep_on_q <= 1'b0;
            pulse_q  <= 1'b0;
            rep_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            cand_q   <= cand_d;
            code_q   <= code_d;
            hold_q   <= hold_d;
            rep_on_q <= rep_on_d;
            pulse_q  <= pulse_d;
            rep_q    <= rep_d;
            rel_q    <= rel_d;
        end
    end

    assign key_pulse   = pulse_q;
    assign key_code    = code_q;
    assign key_rep     = rep_q;
    assign key_release = rel_q;
    assign hold_id     = hold_q;

endmodule

// File: tb/tb_xh_touch_key.sv
// Bench for xh_touch_key: directed scenarios with hand-derived expectations plus randomized
// touch traffic, all compared every cycle against an event-timestamp reference model.
module tb_xh_touch_key;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int TO  = 8;

    localparam int XL[7] = '{16, 272, 272, 780, 528, 528, 16};
    localparam int XH[7] = '{240, 496, 496, 1004, 752, 752, 240};
    localparam int YL[7] = '{244, 244, 444, 44, 244, 444, 444};
    localparam int YH[7] = '{356, 356, 556, 156, 356, 556, 556};

    logic        pix_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        touch_valid = 1'b0;
    logic        touch_down = 1'b0;
    logic [12:0] touch_x = '0;
    logic [12:0] touch_y = '0;
    logic        key_pulse, key_rep, key_release;
    logic [2:0]  key_code, hold_id;

    int total = 0;
    int bad = 0;
    int n_pulse = 0, n_rep = 0, n_rel = 0;

    always #5 pix_clk = ~pix_clk;

    xh_touch_key #(
        .X_BITS(13), .Y_BITS(13), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .TIMEOUT_CYCLES(TO), .CNT_BITS(26)
    ) dut (
        .pix_clk(pix_clk), .rstn(rstn), .touch_valid(touch_valid), .touch_down(touch_down),
        .touch_x(touch_x), .touch_y(touch_y), .key_pulse(key_pulse), .key_code(key_code),
        .key_rep(key_rep), .key_release(key_release), .hold_id(hold_id)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region(input logic d, input int x, input int y);
        if (!d) return 0;
        for (int i = 0; i < 7; i++)
            if (x >= XL[i] && x <= XH[i] && y >= YL[i] && y <= YH[i]) return i + 1;
        return 0;
    endfunction

    // ---------------------------------------------------------------- reference model
    // Timing is tracked as edge numbers: when a phase began, when the finger was last
    // confirmed, and repeats are computed arithmetically from the press edge.
    localparam int PIdle = 0, PDeb = 1, PPress = 2, PRel = 3;
    int m_ph, m_cand, e_cnt, t0, g0, s_hit, m_code, m_hold;
    bit s_v, m_pulse, m_rep, m_rel;

    initial begin
        forever begin
            @(posedge pix_clk or negedge rstn);
            if (!rstn) begin
                m_ph = PIdle; m_cand = 0; e_cnt = 0; t0 = 0; g0 = 0; s_v = 0; s_hit = 0;
                m_code = 0; m_hold = 0; m_pulse = 0; m_rep = 0; m_rel = 0;
            end else begin
                int d;
                e_cnt++;
                d = e_cnt - t0;
                m_pulse = 0; m_rep = 0; m_rel = 0;
                case (m_ph)
                    PIdle: if (s_v && s_hit != 0) begin
                        m_ph = PDeb; m_cand = s_hit; t0 = e_cnt;
                    end
                    PDeb: begin
                        if (s_v && s_hit != m_cand) m_ph = PIdle;
                        else if (d == DEB) begin
                            m_ph = PPress; t0 = e_cnt; g0 = e_cnt;
                            m_pulse = 1; m_code = m_cand; m_hold = m_cand;
                        end else if (!s_v && d == TO) m_ph = PIdle;
                    end
                    PPress: begin
                        if ((s_v && s_hit != m_cand) || (!s_v && e_cnt - g0 == TO)) begin
                            m_ph = PRel; t0 = e_cnt;
                        end else begin
                            if (s_v) g0 = e_cnt;
                            if ((m_cand == 5 || m_cand == 6) && d >= RD && (d - RD) % RP == 0) begin
                                m_pulse = 1; m_rep = 1; m_code = m_cand;
                            end
                        end
                    end
                    default: begin
                        if (s_v && s_hit == m_cand) begin
                            m_ph = PPress; t0 = e_cnt; g0 = e_cnt;
                        end else if (d == DEB) begin
                            m_rel = 1; m_hold = 0; m_ph = PIdle;
                        end
                    end
                endcase
                s_v = touch_valid;
                s_hit = region(touch_down, int'(touch_x), int'(touch_y));
            end
        end
    end

    // ---------------------------------------------------------------- per-cycle compare
    initial begin
        forever begin
            @(negedge pix_clk);
            if (rstn) begin
                chk("key_pulse", int'(key_pulse), int'(m_pulse));
                chk("key_rep", int'(key_rep), int'(m_rep));
                chk("key_release", int'(key_release), int'(m_rel));
                chk("key_code", int'(key_code), m_code);
                chk("hold_id", int'(hold_id), m_hold);
                if (key_pulse) n_pulse++;
                if (key_rep) n_rep++;
                if (key_release) n_rel++;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send(input logic d, input int x, input int y);
        @(posedge pix_clk); #1;
        touch_valid = 1'b1; touch_down = d; touch_x = 13'(x); touch_y = 13'(y);
        @(posedge pix_clk); #1;
        touch_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pix_clk);
        #1;
    endtask

    // Cycles from now until key_release is seen; -1 if it never comes within the budget.
    task automatic rel_latency(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge pix_clk); #1;
            if (key_release) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pick(input int id, output int x, output int y);
        int m;
        if (id == 0) begin
            x = $urandom_range(0, 1279);
            y = $urandom_range(0, 719);
        end else begin
            m = $urandom_range(0, 5);
            x = XL[id-1] + $urandom_range(0, XH[id-1] - XL[id-1]);
            y = YL[id-1] + $urandom_range(0, YH[id-1] - YL[id-1]);
            case (m)
                1: x = XL[id-1];
                2: y = YH[id-1];
                3: x = XL[id-1] - 1;
                4: y = YH[id-1] + 1;
                default: ;
            endcase
        end
    endtask

    int ex[5] = '{16, 240, 241, 1004, 1005};
    int ey[5] = '{244, 356, 300, 156, 156};
    int eid[5] = '{1, 1, 0, 4, 0};

    initial begin
        int p0, r0, l0, lat, x, y;

        #12;
        chk("reset_pulse", int'(key_pulse), 0);
        chk("reset_code", int'(key_code), 0);
        chk("reset_hold", int'(hold_id), 0);
        chk("reset_release", int'(key_release), 0);
        #10 rstn = 1'b1;
        idle(2);

        // Clean press on ID2.
        p0 = n_pulse; r0 = n_rep; l0 = n_rel;
        repeat (4) send(1, 300, 300);
        chk("clean_hold", int'(hold_id), 2);
        repeat (6) send(1, 300, 300);
        send(0, 300, 300);
        rel_latency(lat);
        chk("clean_rel_latency", lat, 5);
        idle(4);
        chk("clean_pulses", n_pulse - p0, 1);
        chk("clean_reps", n_rep - r0, 0);
        chk("clean_releases", n_rel - l0, 1);
        chk("clean_code_kept", int'(key_code), 2);
        chk("clean_hold_after", int'(hold_id), 0);

        // Rectangle edges.
        for (int i = 0; i < 5; i++) begin
            p0 = n_pulse;
            repeat (5) send(1, ex[i], ey[i]);
            chk("edge_hold", int'(hold_id), eid[i]);
            send(0, 0, 0);
            idle(8);
            chk("edge_pulses", n_pulse - p0, (eid[i] != 0) ? 1 : 0);
        end

        // Bounce on ID3.
        p0 = n_pulse;
        send(1, 300, 500);
        send(0, 300, 500);
        repeat (6) send(1, 300, 500);
        send(0, 300, 500);
        idle(8);
        chk("bounce_pulses", n_pulse - p0, 1);

        // Auto-repeat on ID5, none on ID1.
        p0 = n_pulse; r0 = n_rep;
        repeat (15) send(1, 600, 300);
        send(0, 600, 300);
        idle(8);
        chk("repeat_pulses", n_pulse - p0, 5);
        chk("repeat_reps", n_rep - r0, 4);
        p0 = n_pulse; r0 = n_rep;
        repeat (15) send(1, 100, 300);
        send(0, 100, 300);
        idle(8);
        chk("norepeat_pulses", n_pulse - p0, 1);
        chk("norepeat_reps", n_rep - r0, 0);

        // Report timeout on ID7.
        l0 = n_rel;
        repeat (5) send(1, 100, 500);
        rel_latency(lat);
        chk("timeout_latency", lat, 13);
        idle(4);
        chk("timeout_releases", n_rel - l0, 1);

        // Asynchronous reset while ID4 is held.
        repeat (5) send(1, 900, 100);
        chk("rst_hold_before", int'(hold_id), 4);
        l0 = n_rel;
        @(negedge pix_clk); #2;
        rstn = 1'b0;
        #1;
        chk("rst_hold", int'(hold_id), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_pulse", int'(key_pulse), 0);
        chk("rst_release", int'(key_release), 0);
        idle(3);
        rstn = 1'b1;
        send(0, 900, 100);
        send(0, 900, 100);
        idle(10);
        chk("rst_no_release", n_rel - l0, 0);
        chk("rst_hold_after", int'(hold_id), 0);

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            int id, n;
            id = $urandom_range(0, 7);
            n = $urandom_range(1, 20);
            pick(id, x, y);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 12));
                if ($urandom_range(0, 9) == 0) pick($urandom_range(0, 7), x, y);
                send(($urandom_range(0, 9) != 0), x, y);
            end
            if ($urandom_range(0, 1) == 1) send(0, x, y);
            idle($urandom_range(0, 14));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xh_touch_key.md
Name: xh_touch_key

Overview:
- Input-side counterpart of the on-screen button overlay: converts touch-panel coordinate reports into debounced button events.
- Uses the same seven button rectangles (1280x720 screen space) that the overlay draws.
- Sits between the touch-controller reader and the oscilloscope control logic.
- Also returns the currently held button ID so the overlay can highlight it.

Parameters:
- X_BITS, 13, width of touch_x
- Y_BITS, 13, width of touch_y
- DEB_CYCLES, 1485000, press/release debounce length in pix_clk cycles (20 ms at 74.25 MHz)
- REPEAT_DELAY, 37125000, hold time before auto-repeat starts (500 ms)
- REPEAT_PERIOD, 7425000, auto-repeat interval (100 ms)
- TIMEOUT_CYCLES, 7425000, gap in touch reports that counts as a release (100 ms)
- CNT_BITS, 26, width of the shared timer; must hold max(all cycle parameters)

Ports:
- pix_clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- touch_valid  input  1  one-cycle strobe; a new touch report is present
- touch_down  input  1  finger present in this report
- touch_x  input  X_BITS  report X coordinate
- touch_y  input  Y_BITS  report Y coordinate
- key_pulse  output  1  one-cycle press/repeat event
- key_code  output  3  button ID of the last event; held between events
- key_rep  output  1  high with key_pulse when the event is an auto-repeat
- key_release  output  1  one-cycle pulse when a held button is released
- hold_id  output  3  ID of the button currently held, 0 if none

Behaviour:
- Reset (rstn low, async): state IDLE, timer 0, candidate 0; all outputs 0.
- Input stage: on touch_valid, register touch_down/x/y and raise a one-cycle sample flag.
- Hit-test: combinational on the registered sample; all bounds inclusive.
  - ID1: x 16..240, y 244..356 (waveform)
  - ID2: x 272..496, y 244..356 (frequency)
  - ID3: x 272..496, y 444..556 (amplitude)
  - ID4: x 780..1004, y 44..156 (return)
  - ID5: x 528..752, y 244..356 (+/- upper)
  - ID6: x 528..752, y 444..556 (+/- lower)
  - ID7: x 16..240, y 444..556 (reset)
  - hit = 0 if touch_down = 0 or no region matches. Regions are disjoint.
- Latency: the sample is evaluated one cycle after touch_valid.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE:
  - Sample with hit != 0: cand <= hit, timer <= 0, go to DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - Timer increments every cycle.
  - Sample with hit != cand: go to IDLE; the next sample restarts detection.
  - Timer reaches TIMEOUT_CYCLES-1 with no sample: go to IDLE.
  - Timer reaches DEB_CYCLES-1: go to PRESSED. Same cycle: key_pulse = 1, key_code <= cand, key_rep = 0, hold_id <= cand, timer <= 0.
  - If both limits hit in the same cycle, DEB_CYCLES wins.
- PRESSED:
  - Timer counts every cycle. A sample with hit == cand resets a separate gap counter.
  - Release condition: sample with hit != cand (lift or slide off), or gap counter reaches TIMEOUT_CYCLES-1. Go to RELEASE, timer <= 0, hold_id unchanged.
  - Auto-repeat applies to IDs 5 and 6 only:
    - First repeat when timer == REPEAT_DELAY-1; then every REPEAT_PERIOD cycles.
    - Each repeat gives key_pulse = 1 and key_rep = 1.
  - If a release condition and a repeat fall in the same cycle, the release wins and no pulse is emitted.
- RELEASE:
  - Timer increments.
  - Sample with hit == cand: go back to PRESSED (bounce). No new pulse; the repeat schedule restarts from REPEAT_DELAY.
  - Timer reaches DEB_CYCLES-1: key_release = 1 for one cycle, hold_id <= 0, go to IDLE.
- key_code is never cleared by release, only by reset.
- Widths: coordinate comparisons use full X_BITS/Y_BITS; no truncation.
- Reset mid-press: outputs drop to 0 immediately and no key_release pulse is emitted.

Test Plan:
Common parameters: DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, TIMEOUT_CYCLES=8; touch_valid every 2 cycles.
- Clean press, ID2 (x=300, y=300) held 20 cycles, then down=0 → one key_pulse with key_code=2, key_rep=0; hold_id=2 throughout; key_release 4 cycles after the first down=0 sample; hold_id=0 afterwards.
- Edges (16,244), (240,356), (241,300), (1004,156), (1005,156) → IDs 1, 1, 0, 4, 0 respectively.
- Bounce: ID3 down for 2 cycles, up, down again → no pulse until 4 stable cycles; exactly one pulse total.
- Auto-repeat: ID5 (600,300) held 30 cycles → pulses at press, +10, +15, +20, +25; all after the first have key_rep=1. Repeat test on ID1 → single pulse only.
- Timeout: ID7 pressed, then touch_valid stops → key_release 8+4 cycles after the last sample.
- Async reset: rstn low while in PRESSED on ID4 → hold_id, key_pulse, key_code = 0 immediately; no key_release; IDLE after rstn high.
